if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
REQ-002 Instruction-memory ports SHALL be:
- im_addr  output  16  fetch address; equals pc combinationally
- im_rd_en  output  1  fetch enable; 1 in RUN, 0 in HALT
- im_instr  input  16  instruction word, valid in the same cycle as im_addr
REQ-003 Control ports SHALL be:
- stall  input  1  hold PC and IF/ID register
- redirect  input  1  taken branch/jal/jr resolved in decode
- redirect_addr  input  16  new PC when redirect=1
REQ-004 Decode-stage ports SHALL be:
- id_instr  output  16  registered instruction to decode
- id_addr  output  16  registered PC+1 of id_instr
- id_valid  output  1  id_instr is a real instruction, not a bubble
- halted  output  1  1 in the HALT state

Function
REQ-005 pc SHALL be a 16-bit register; increment SHALL wrap 0xFFFF to 0x0000.
REQ-006 The FSM SHALL have two states, RUN and HALT.
REQ-007 Each cycle the first matching rule SHALL apply:
1. redirect=1
2. HALT
3. stall=1
4. normal fetch
REQ-008 Rule 1, redirect (RUN or HALT, regardless of stall): pc<=redirect_addr, IF/ID<=bubble, state<=RUN.
REQ-009 Rule 2, HALT without redirect: pc holds. If stall=0, IF/ID<=bubble; if stall=1, IF/ID holds.
REQ-010 Rule 3, stall in RUN: pc, IF/ID and state SHALL hold unchanged.
REQ-011 Rule 4, normal fetch: id_instr<=im_instr, id_addr<=pc+1, id_valid<=1, pc<=pc+1.
REQ-012 In rule 4, if im_instr[15:12]==4'hF: the halt word SHALL still be loaded into IF/ID, pc SHALL hold, and state<=HALT.
REQ-013 A bubble SHALL be id_instr=0x0000, id_addr=0x0000, id_valid=0.
REQ-014 Redirect and halt-fetch in the same cycle: redirect wins and HALT is not entered.
REQ-015 Each fetched instruction SHALL reach id_instr exactly one cycle after im_addr presented it; there are no combinational paths from inputs to id_* outputs.
REQ-016 halted SHALL be a pure function of the state register.

Reset
REQ-017 While rst_n=0, asynchronously: pc=0x0000, state=RUN, IF/ID=bubble, halted=0; im_rd_en=1 takes effect on the first clock after release.
REQ-018 Reset mid-stall, mid-redirect or in HALT SHALL discard all in-flight state; the first fetch after release is address 0x0000.

Configuration
REQ-019 Macro IF_STAGE_FETCH_CNT_EN:
- Defined: adds output fetch_cnt (16 bits), incremented on every rule-4 cycle, saturating at 0xFFFF, reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Structure
REQ-020 The shared cpu package SHALL hold:
- the state enum (RUN, HALT)
- the HLT opcode constant 4'hF
- the bubble constant 0x0000
- the reset vector 0x0000
- the instruction and address width (16)
REQ-021 The IF/ID register SHALL be a sub-module if_id_reg with inputs load, flush, hold, d_instr and d_addr; the PC and FSM stay in if_stage.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset release, memory returns 0x1123,0x2456 at 0,1 -> id_instr 0x1123/id_addr 0x0001 at cycle 1, then 0x2456/0x0002 at cycle 2.
- stall=1 for 3 cycles at pc=0x0005 -> im_addr stays 0x0005; id_* unchanged; fetch resumes at 0x0005.
- redirect=1, redirect_addr=0x0040, stall=1 same cycle -> next cycle pc=0x0040, id_valid=0; the following cycle fetches from 0x0040.
- im_instr=0xF000 at pc=0x0010 -> id_instr=0xF000, halted=1, im_rd_en=0, im_addr stays 0x0010; next cycle bubble.
- pc=0xFFFF normal fetch -> id_addr=0x0000, pc wraps to 0x0000.
- With IF_STAGE_FETCH_CNT_EN: 5 fetches, 2 stalls, 1 redirect -> fetch_cnt=5.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared CPU definitions for the fetch stage: state encoding, HLT opcode, bubble and reset vector.
package if_stage_pkg;

    localparam int XLEN   = 16;
    localparam int ADDR_W = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    localparam logic [3:0]        OP_HLT       = 4'hF;
    localparam logic [XLEN-1:0]   BUBBLE_INSTR = 16'h0000;
    localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;

    function automatic logic is_hlt(input logic [XLEN-1:0] instr);
        return instr[XLEN-1:XLEN-4] == OP_HLT;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes, load captures the fetched word.
import if_stage_pkg::*;

module if_id_reg (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic              hold,
    input  logic [XLEN-1:0]   d_instr,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [XLEN-1:0]   q_instr,
    output logic [ADDR_W-1:0] q_addr,
    output logic              q_valid
);

    logic [XLEN-1:0]   instr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              valid_reg;

    // Flush beats hold so a redirect always kills whatever is parked here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg <= BUBBLE_INSTR;
            addr_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            instr_reg <= BUBBLE_INSTR;
            addr_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load && !hold) begin
            instr_reg <= d_instr;
            addr_reg  <= d_addr;
            valid_reg <= 1'b1;
        end
    end

    assign q_instr = instr_reg;
    assign q_addr  = addr_reg;
    assign q_valid = valid_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, RUN/HALT FSM and the IF/ID register.
// Optional macro IF_STAGE_FETCH_CNT_EN adds a saturating fetch_cnt output.
import if_stage_pkg::*;

module if_stage (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_rd_en,
    input  logic [XLEN-1:0]   im_instr,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [XLEN-1:0]   id_instr,
    output logic [ADDR_W-1:0] id_addr,
    output logic              id_valid,
    output logic              halted
`ifdef IF_STAGE_FETCH_CNT_EN
    ,
    output logic [15:0]       fetch_cnt
`endif
);

    logic [ADDR_W-1:0] pc_reg, pc_next, pc_plus1;
    fetch_state_e      state_reg, state_next;
    logic              rd_en_reg;
    logic              ifid_load, ifid_flush, ifid_hold, fetch_go;

    assign pc_plus1 = pc_reg + 16'd1;

    // Priority: redirect, then HALT, then stall, then normal fetch.
    always_comb begin
        pc_next    = pc_reg;
        state_next = state_reg;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b0;
        fetch_go   = 1'b0;
        if (redirect) begin
            pc_next    = redirect_addr;
            ifid_flush = 1'b1;
            state_next = RUN;
        end else if (state_reg == HALT) begin
            if (stall) ifid_hold  = 1'b1;
            else       ifid_flush = 1'b1;
        end else if (stall) begin
            ifid_hold = 1'b1;
        end else begin
            fetch_go  = 1'b1;
            ifid_load = 1'b1;
            if (is_hlt(im_instr)) state_next = HALT;
            else                  pc_next    = pc_plus1;
        end
    end

    // rd_en comes out of reset low and tracks the state from the first edge on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= RESET_VECTOR;
            state_reg <= RUN;
            rd_en_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            state_reg <= state_next;
            rd_en_reg <= (state_next == RUN);
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .hold    (ifid_hold),
        .d_instr (im_instr),
        .d_addr  (pc_plus1),
        .q_instr (id_instr),
        .q_addr  (id_addr),
        .q_valid (id_valid)
    );

    assign im_addr  = pc_reg;
    assign im_rd_en = rd_en_reg;
    assign halted   = (state_reg == HALT);

`ifdef IF_STAGE_FETCH_CNT_EN
    logic [15:0] fetch_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_cnt_reg <= '0;
        else if (fetch_go && fetch_cnt_reg != 16'hFFFF)
            fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
    end

    assign fetch_cnt = fetch_cnt_reg;
`else
    logic unused_fetch_go;
    assign unused_fetch_go = fetch_go;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table with expected-result queue plus reset corner cases.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_instr;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic [15:0] id_instr;
    logic [15:0] id_addr;
    logic        id_valid;
    logic        halted;
`ifdef IF_STAGE_FETCH_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .im_addr       (im_addr),
        .im_rd_en      (im_rd_en),
        .im_instr      (im_instr),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .id_instr      (id_instr),
        .id_addr       (id_addr),
        .id_valid      (id_valid),
        .halted        (halted)
`ifdef IF_STAGE_FETCH_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt)
`endif
    );

    // Instruction memory model: a few fixed words, everything else opcode 3 tagged with its address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1123;
            16'h0001: return 16'h2456;
            16'h0010: return 16'hF000;
            default:  return {4'h3, a[11:0]};
        endcase
    endfunction

    always_comb im_instr = mem_word(im_addr);

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] raddr;
        logic [15:0] e_instr;
        logic [15:0] e_addr;
        logic        e_valid;
        logic        e_halted;
        logic [15:0] e_im_addr;
        logic        e_rd_en;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic s, input logic r, input logic [15:0] ra,
                                input logic [15:0] ei, input logic [15:0] ea, input logic ev,
                                input logic eh, input logic [15:0] eim, input logic erd);
        vec_t v;
        v.stall = s; v.redirect = r; v.raddr = ra;
        v.e_instr = ei; v.e_addr = ea; v.e_valid = ev;
        v.e_halted = eh; v.e_im_addr = eim; v.e_rd_en = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [15:0] ra);
        stall = s; redirect = r; redirect_addr = ra;
    endtask

    initial begin
        vec_t e;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);

        // Expected post-edge outputs: stall, redirect, raddr | id_instr, id_addr, valid, halted, im_addr, rd_en
        vecs.push_back(mk(0,0,16'h0000, 16'h1123,16'h0001,1,0,16'h0001,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h2456,16'h0002,1,0,16'h0002,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h3002,16'h0003,1,0,16'h0003,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h3003,16'h0004,1,0,16'h0004,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h3004,16'h0005,1,0,16'h0005,1));
        vecs.push_back(mk(1,0,16'h0000, 16'h3004,16'h0005,1,0,16'h0005,1));
        vecs.push_back(mk(1,0,16'h0000, 16'h3004,16'h0005,1,0,16'h0005,1));
        vecs.push_back(mk(1,0,16'h0000, 16'h3004,16'h0005,1,0,16'h0005,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h3005,16'h0006,1,0,16'h0006,1));
        vecs.push_back(mk(1,1,16'h0040, 16'h0000,16'h0000,0,0,16'h0040,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h3040,16'h0041,1,0,16'h0041,1));
        vecs.push_back(mk(0,1,16'h000E, 16'h0000,16'h0000,0,0,16'h000E,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h300E,16'h000F,1,0,16'h000F,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h300F,16'h0010,1,0,16'h0010,1));
        vecs.push_back(mk(0,0,16'h0000, 16'hF000,16'h0011,1,1,16'h0010,0));
        vecs.push_back(mk(1,0,16'h0000, 16'hF000,16'h0011,1,1,16'h0010,0));
        vecs.push_back(mk(0,0,16'h0000, 16'h0000,16'h0000,0,1,16'h0010,0));
        vecs.push_back(mk(0,0,16'h0000, 16'h0000,16'h0000,0,1,16'h0010,0));
        vecs.push_back(mk(0,1,16'hFFFF, 16'h0000,16'h0000,0,0,16'hFFFF,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h3FFF,16'h0000,1,0,16'h0000,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h1123,16'h0001,1,0,16'h0001,1));
        vecs.push_back(mk(0,1,16'h0010, 16'h0000,16'h0000,0,0,16'h0010,1));
        vecs.push_back(mk(0,1,16'h0020, 16'h0000,16'h0000,0,0,16'h0020,1));
        vecs.push_back(mk(0,0,16'h0000, 16'h3020,16'h0021,1,0,16'h0021,1));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_id_instr", id_instr, 16'h0000);
        chk("reset_id_addr",  id_addr,  16'h0000);
        chk("reset_id_valid", {15'd0, id_valid}, 16'h0000);
        chk("reset_halted",   {15'd0, halted},   16'h0000);
        chk("reset_im_addr",  im_addr,  16'h0000);
`ifdef IF_STAGE_FETCH_CNT_EN
        chk("reset_fetch_cnt", fetch_cnt, 16'h0000);
`endif

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].stall, vecs[i].redirect, vecs[i].raddr);
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            $display("vec %0d: stall=%0b redir=%0b im_addr=%h id_instr=%h id_addr=%h valid=%0b halted=%0b",
                     i, e.stall, e.redirect, im_addr, id_instr, id_addr, id_valid, halted);
            chk($sformatf("v%0d_id_instr", i), id_instr, e.e_instr);
            chk($sformatf("v%0d_id_addr", i),  id_addr,  e.e_addr);
            chk($sformatf("v%0d_id_valid", i), {15'd0, id_valid}, {15'd0, e.e_valid});
            chk($sformatf("v%0d_halted", i),   {15'd0, halted},   {15'd0, e.e_halted});
            chk($sformatf("v%0d_im_addr", i),  im_addr,  e.e_im_addr);
            chk($sformatf("v%0d_im_rd_en", i), {15'd0, im_rd_en}, {15'd0, e.e_rd_en});
        end

        // Asynchronous reset while in HALT, then first fetch comes from address 0.
        @(negedge clk); drive(1'b0, 1'b1, 16'h0010);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        chk("halt_before_reset", {15'd0, halted}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_halt_halted",   {15'd0, halted},   16'h0000);
        chk("rst_halt_im_addr",  im_addr,           16'h0000);
        chk("rst_halt_id_valid", {15'd0, id_valid}, 16'h0000);
        chk("rst_halt_id_instr", id_instr,          16'h0000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_id_instr", id_instr, 16'h1123);
        chk("post_rst_id_addr",  id_addr,  16'h0001);
        $display("seq reset_in_halt: id_instr=%h id_addr=%h", id_instr, id_addr);

        // Asynchronous reset in the middle of a stall.
        @(negedge clk); drive(1'b0, 1'b0, 16'h0000);
        @(negedge clk); drive(1'b1, 1'b0, 16'h0000);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_stall_im_addr",  im_addr,           16'h0000);
        chk("rst_stall_id_valid", {15'd0, id_valid}, 16'h0000);
        @(negedge clk); rst_n = 1'b1; drive(1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        chk("rst_stall_first_fetch", id_instr, 16'h1123);
        chk("rst_stall_id_addr",     id_addr,  16'h0001);
        $display("seq reset_mid_stall: id_instr=%h id_addr=%h", id_instr, id_addr);

`ifdef IF_STAGE_FETCH_CNT_EN
        // Counter: 5 fetches, 2 stalls, 1 redirect after a fresh reset.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (5) begin drive(1'b0, 1'b0, 16'h0000); @(negedge clk); end
        repeat (2) begin drive(1'b1, 1'b0, 16'h0000); @(negedge clk); end
        drive(1'b0, 1'b1, 16'h0040); @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000);
        chk("fetch_cnt", fetch_cnt, 16'd5);
        $display("seq fetch_cnt: fetch_cnt=%0d", fetch_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
